// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core (port 0) and a debug/loader master
// (port 1). Optional hold-grant lock enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                  lock0,
  input  logic                  lock1,
`endif
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ctrl_mem_w,
  output logic                  ctrl_mem_r,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data
);

  logic                  last_q, last_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_owner_q, rd_owner_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  elig0, elig1;
  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic {StUnlocked, StLocked} lock_state_e;

  lock_state_e lock_state_q, lock_state_d;
  logic        lock_owner_q, lock_owner_d;
  logic        owner_req, owner_lock;

  // A locked FSM masks the non-owner out of arbitration entirely.
  always_comb begin
    elig0 = req0;
    elig1 = req1;
    if (lock_state_q == StLocked) begin
      if (lock_owner_q) begin
        elig0 = 1'b0;
      end else begin
        elig1 = 1'b0;
      end
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    lock_owner_d = lock_owner_q;
    owner_req    = lock_owner_q ? req1 : req0;
    owner_lock   = lock_owner_q ? lock1 : lock0;
    case (lock_state_q)
      StUnlocked: begin
        if (any_gnt && (gnt1 ? lock1 : lock0)) begin
          lock_state_d = StLocked;
          lock_owner_d = gnt1;
        end
      end
      StLocked: begin
        // While locked, any grant necessarily goes to the owner.
        if (!owner_req || (any_gnt && !owner_lock)) begin
          lock_state_d = StUnlocked;
        end
      end
      default: lock_state_d = StUnlocked;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_q <= StUnlocked;
      lock_owner_q <= 1'b0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  always_comb begin
    elig0 = req0;
    elig1 = req1;
  end
`endif

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? we1 : we0;
    sel_addr  = gnt1 ? addr1 : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;

    ctrl_mem_w  = any_gnt & sel_we;
    ctrl_mem_r  = any_gnt & ~sel_we;
    mem_address = any_gnt ? sel_addr : '0;
    mem_w_data  = any_gnt ? sel_wdata : '0;
  end

  always_comb begin
    last_d     = any_gnt ? gnt1 : last_q;
    rd_pend_d  = ctrl_mem_r;
    rd_owner_d = ctrl_mem_r ? gnt1 : rd_owner_q;
    rdata_d    = rd_pend_q ? mem_r_data : rdata_q;
  end

  // Read return is suppressed while reset is asserted, even if a read was in flight.
  always_comb begin
    rvalid0 = ~rst & rd_pend_q & ~rd_owner_q;
    rvalid1 = ~rst & rd_pend_q & rd_owner_q;
    rdata   = rst ? '0 : rdata_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
